fitness_sequencer: RTL and testbench

Evaluation sequencer for the evolvable LUT-grid circuit. Latches one candidate chromosome and holds it stable on the circuit's configuration input. Sweeps every input vector of the combinational genetic circuit, compares each response bit-by-bit against a target truth table held in a synchronous ROM, and reports the number of matching output bits as the chromosome's fitness. Sits between the genetic-search engine (chromosome producer) and the genetic-circuit instance.

---
 rtl/fitness_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_fitness_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fitness_sequencer.sv
// ---------------------------------------------------------------------------
// fitness_sequencer
//
// Evaluation sequencer for the evolvable LUT-grid circuit. On an accepted
// start it latches one chromosome onto the circuit's configuration input,
// then walks every input vector 0..2^IN-1. For each vector it waits SETTLE
// cycles, then compares the circuit response with the target truth table
// (synchronous ROM, 1-cycle latency) and adds the number of matching bits
// to a running score. The final score is reported as the fitness.
//
// Optional feature (macro FITNESS_BEST_TRACK_EN):
//   defined     -> best_fitness / best_chrom track the strictly best result
//                  since reset (ties keep the earlier chromosome)
//   not defined -> best_fitness / best_chrom are constant 0
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   start        begin evaluation of chrom_in (honoured in IDLE only)
//   abort        cancel evaluation in progress (SETTLE / SAMPLE only)
//   chrom_in     candidate chromosome, sampled with start
//   chrom_out    chromosome driven to the genetic circuit
//   inp_out      input vector driven to the genetic circuit
//   circ_out     genetic circuit response (combinational)
//   tgt_addr     target ROM address (same as inp_out)
//   tgt_data     target ROM data, 1-cycle read latency
//   busy         evaluation in progress
//   done         one-cycle completion pulse
//   fitness      matching-bit count of the last completed evaluation
//   perfect      fitness == 2^IN * OUT
//   best_fitness best fitness seen
//   best_chrom   chromosome that achieved best_fitness
// ---------------------------------------------------------------------------
module fitness_sequencer #(
   parameter int IN      = 10,
   parameter int OUT     = 10,
   parameter int CHROM_W = 33,
   parameter int SETTLE  = 2,
   parameter int FIT_W   = $clog2((2**IN)*OUT+1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [CHROM_W-1:0] chrom_in,
   output logic [CHROM_W-1:0] chrom_out,
   output logic [IN-1:0]      inp_out,
   input  logic [OUT-1:0]     circ_out,
   output logic [IN-1:0]      tgt_addr,
   input  logic [OUT-1:0]     tgt_data,
   output logic               busy,
   output logic               done,
   output logic [FIT_W-1:0]   fitness,
   output logic               perfect,
   output logic [FIT_W-1:0]   best_fitness,
   output logic [CHROM_W-1:0] best_chrom
);

   localparam int N     = 1 << IN;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [FIT_W-1:0] MAX_SCORE  = FIT_W'(N * OUT);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
   localparam logic [IN-1:0]    LAST_VEC   = {IN{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t               state_reg,   state_next;
   logic [IN-1:0]        vec_reg,     vec_next;
   logic [CNT_W-1:0]     cnt_reg,     cnt_next;
   logic [FIT_W-1:0]     score_reg,   score_next;
   logic [CHROM_W-1:0]   chrom_reg,   chrom_next;
   logic [FIT_W-1:0]     fitness_reg, fitness_next;
   logic                 perfect_reg, perfect_next;

   // Per-bit agreement between circuit response and target row.
   logic [OUT-1:0]       match_bits;
   logic [FIT_W-1:0]     match_count;
   logic [FIT_W-1:0]     score_sum;

   genvar gi;
   generate
      for (gi = 0; gi < OUT; gi++) begin : g_match
         assign match_bits[gi] = ~(circ_out[gi] ^ tgt_data[gi]);
      end
   endgenerate

   always_comb begin
      match_count = '0;
      for (int i = 0; i < OUT; i++) begin
         match_count = match_count + FIT_W'(match_bits[i]);
      end
   end

   // Cannot overflow: the score never exceeds N*OUT, which fits in FIT_W.
   assign score_sum = score_reg + match_count;

`ifdef FITNESS_BEST_TRACK_EN
   logic [FIT_W-1:0]     best_fitness_reg, best_fitness_next;
   logic [CHROM_W-1:0]   best_chrom_reg,   best_chrom_next;
`endif

   // Next-state and datapath updates
   always_comb begin
      state_next   = state_reg;
      vec_next     = vec_reg;
      cnt_next     = cnt_reg;
      score_next   = score_reg;
      chrom_next   = chrom_reg;
      fitness_next = fitness_reg;
      perfect_next = perfect_reg;
`ifdef FITNESS_BEST_TRACK_EN
      best_fitness_next = best_fitness_reg;
      best_chrom_next   = best_chrom_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            // start has priority over a simultaneous abort, which is
            // meaningless in IDLE anyway.
            if (start) begin
               chrom_next = chrom_in;
               vec_next   = '0;
               score_next = '0;
               cnt_next   = CNT_RELOAD;
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            // vec is held here, so the ROM output is aligned by SAMPLE.
            if (abort) begin
               state_next = ST_IDLE;
            end else if (cnt_reg == '0) begin
               state_next = ST_SAMPLE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (vec_reg == LAST_VEC) begin
               score_next   = score_sum;
               fitness_next = score_sum;
               perfect_next = (score_sum == MAX_SCORE);
               state_next   = ST_DONE;
            end else begin
               score_next = score_sum;
               vec_next   = vec_reg + IN'(1);
               cnt_next   = CNT_RELOAD;
               state_next = ST_SETTLE;
            end
         end
         ST_DONE: begin
`ifdef FITNESS_BEST_TRACK_EN
            // Strictly greater: a tie keeps the earlier chromosome.
            if (fitness_reg > best_fitness_reg) begin
               best_fitness_next = fitness_reg;
               best_chrom_next   = chrom_reg;
            end
`endif
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         vec_reg     <= '0;
         cnt_reg     <= '0;
         score_reg   <= '0;
         chrom_reg   <= '0;
         fitness_reg <= '0;
         perfect_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         vec_reg     <= vec_next;
         cnt_reg     <= cnt_next;
         score_reg   <= score_next;
         chrom_reg   <= chrom_next;
         fitness_reg <= fitness_next;
         perfect_reg <= perfect_next;
      end
   end

`ifdef FITNESS_BEST_TRACK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         best_fitness_reg <= '0;
         best_chrom_reg   <= '0;
      end else begin
         best_fitness_reg <= best_fitness_next;
         best_chrom_reg   <= best_chrom_next;
      end
   end

   assign best_fitness = best_fitness_reg;
   assign best_chrom   = best_chrom_reg;
`else
   assign best_fitness = '0;
   assign best_chrom   = '0;
`endif

   assign chrom_out = chrom_reg;
   assign inp_out   = vec_reg;
   assign tgt_addr  = vec_reg;
   assign busy      = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE);
   assign done      = (state_reg == ST_DONE);
   assign fitness   = fitness_reg;
   assign perfect   = perfect_reg;

endmodule

// File: tb/tb_fitness_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fitness_sequencer
//
// Directed bench for fitness_sequencer at default parameters. A table of
// {circuit mode, ROM mode, chromosome, expected fitness, expected perfect}
// records is run through complete evaluations; hand-written sequences cover
// abort, ignored start, mid-evaluation reset and best-result tracking.
// ---------------------------------------------------------------------------
module tb_fitness_sequencer;

   localparam int IN       = 10;
   localparam int OUT      = 10;
   localparam int CHROM_W  = 33;
   localparam int FIT_W    = 14;
   localparam int DONE_CYC = 3073;
   localparam int BUSY_CYC = 3072;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               abort;
   logic [CHROM_W-1:0] chrom_in;
   logic [CHROM_W-1:0] chrom_out;
   logic [IN-1:0]      inp_out;
   logic [OUT-1:0]     circ_out;
   logic [IN-1:0]      tgt_addr;
   logic [OUT-1:0]     tgt_data;
   logic               busy;
   logic               done;
   logic [FIT_W-1:0]   fitness;
   logic               perfect;
   logic [FIT_W-1:0]   best_fitness;
   logic [CHROM_W-1:0] best_chrom;

   int n_checks = 0;
   int n_fail   = 0;

   // Circuit and ROM models
   logic circ_inv = 1'b0;
   logic rom_xor  = 1'b0;

   assign circ_out = circ_inv ? ~inp_out : inp_out;

   always_ff @(posedge clk) begin
      tgt_data <= rom_xor ? (tgt_addr ^ 10'h001) : tgt_addr;
   end

   always #5 clk = ~clk;

   fitness_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .chrom_in     (chrom_in),
      .chrom_out    (chrom_out),
      .inp_out      (inp_out),
      .circ_out     (circ_out),
      .tgt_addr     (tgt_addr),
      .tgt_data     (tgt_data),
      .busy         (busy),
      .done         (done),
      .fitness      (fitness),
      .perfect      (perfect),
      .best_fitness (best_fitness),
      .best_chrom   (best_chrom)
   );

   typedef struct {
      logic               circ_inv;
      logic               rom_xor;
      logic [CHROM_W-1:0] chrom;
      int                 exp_fit;
      logic               exp_perf;
   } vec_t;

   vec_t tbl[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Full evaluation: accept edge is cycle 0; returns one cycle after done.
   task automatic run_eval(input logic [CHROM_W-1:0] ch, input int exp_fit,
                           input logic exp_perf, input string tag);
      int done_cyc;
      int busy_cyc;
      @(negedge clk);
      chrom_in = ch;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      done_cyc = -1;
      busy_cyc = 0;
      for (int c = 1; c < 5000; c++) begin
         if (done) begin
            done_cyc = c;
            break;
         end
         if (busy) busy_cyc++;
         @(posedge clk);
         #1;
      end
      check({tag, " done_cycle"}, done_cyc, DONE_CYC);
      check({tag, " busy_cycles"}, busy_cyc, BUSY_CYC);
      check({tag, " busy_in_done"}, busy, 0);
      check({tag, " fitness"}, fitness, exp_fit);
      check({tag, " perfect"}, perfect, exp_perf);
      check({tag, " chrom_out"}, chrom_out, ch);
      @(posedge clk);
      #1;
      check({tag, " done_one_cycle"}, done, 0);
      $display("eval %s: chrom=%h fitness=%0d perfect=%0d done_cycle=%0d",
               tag, ch, fitness, perfect, done_cyc);
   endtask

   initial begin
      logic [CHROM_W-1:0] ch_a, ch_b, ch_c, ch_d, ch_x, ch_r;
      int                 exp_bf;
      logic [CHROM_W-1:0] exp_bc;
      logic               saw_done;

      tbl[0] = '{1'b0, 1'b0, 33'h1_2345_6789, 10240, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 33'h0_DEAD_BEEF, 0,     1'b0};
      tbl[2] = '{1'b1, 1'b1, 33'h1_0F0F_0F0F, 1024,  1'b0};
      tbl[3] = '{1'b0, 1'b1, 33'h0_5555_AAAA, 9216,  1'b0};

      reset    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      chrom_in = 33'h1_FFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      check("reset chrom_out", chrom_out, 0);
      check("reset inp_out", inp_out, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset fitness", fitness, 0);
      check("reset perfect", perfect, 0);
      check("reset best_fitness", best_fitness, 0);
      check("reset best_chrom", best_chrom, 0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven full evaluations
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         circ_inv = tbl[i].circ_inv;
         rom_xor  = tbl[i].rom_xor;
         run_eval(tbl[i].chrom, tbl[i].exp_fit, tbl[i].exp_perf, $sformatf("tbl%0d", i));
      end

      // Abort at cycle 100, with an ignored start at cycle 50
      ch_a = 33'h0_1357_9BDF;
      ch_x = 33'h1_ABCD_EF01;
      circ_inv = 1'b0;
      rom_xor  = 1'b0;
      @(negedge clk);
      chrom_in = ch_a;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c <= 3200; c++) begin
         if (done) saw_done = 1'b1;
         if (c == 50) begin
            start    = 1'b1;
            chrom_in = ch_x;
         end
         if (c == 51) begin
            start = 1'b0;
            check("abort start_ignored chrom_out", chrom_out, ch_a);
         end
         if (c == 100) begin
            check("abort busy_before", busy, 1);
            abort = 1'b1;
         end
         if (c == 101) begin
            abort = 1'b0;
            check("abort busy_after", busy, 0);
         end
         @(posedge clk);
         #1;
      end
      check("abort no_done", saw_done, 0);
      check("abort fitness_kept", fitness, 9216);
      check("abort perfect_kept", perfect, 0);
      check("abort chrom_out", chrom_out, ch_a);
      $display("abort seq: fitness=%0d chrom_out=%h done_seen=%0d", fitness, chrom_out, saw_done);

      // Reset at cycle 500 of an evaluation
      ch_r = 33'h1_0000_0001;
      @(negedge clk);
      chrom_in = ch_r;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c < 500; c++) begin
         @(posedge clk);
         #1;
      end
      check("midreset busy_before", busy, 1);
      check("midreset inp_out_before", inp_out, 166);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset chrom_out", chrom_out, 0);
      check("midreset inp_out", inp_out, 0);
      check("midreset tgt_addr", tgt_addr, 0);
      check("midreset fitness", fitness, 0);
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset perfect", perfect, 0);
      check("midreset best_fitness", best_fitness, 0);
      check("midreset best_chrom", best_chrom, 0);
      @(negedge clk);
      reset = 1'b0;
      $display("mid-eval reset: outputs cleared, restarting");
      run_eval(ch_r, 10240, 1'b1, "after_reset");

      // Best-result tracking: A 9216, B 10240, C 0, D ties B
      do_reset();
      ch_a = 33'h0_AAAA_0001;
      ch_b = 33'h0_BBBB_0002;
      ch_c = 33'h0_CCCC_0003;
      ch_d = 33'h0_DDDD_0004;
      circ_inv = 1'b0;
      rom_xor  = 1'b1;
      run_eval(ch_a, 9216, 1'b0, "best_A");
      rom_xor = 1'b0;
      run_eval(ch_b, 10240, 1'b1, "best_B");
      circ_inv = 1'b1;
      run_eval(ch_c, 0, 1'b0, "best_C");
      circ_inv = 1'b0;
      run_eval(ch_d, 10240, 1'b1, "best_D");
`ifdef FITNESS_BEST_TRACK_EN
      exp_bf = 10240;
      exp_bc = ch_b;
`else
      exp_bf = 0;
      exp_bc = '0;
`endif
      check("best_fitness", best_fitness, exp_bf);
      check("best_chrom", best_chrom, exp_bc);
      $display("best tracking: best_fitness=%0d best_chrom=%h", best_fitness, best_chrom);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
